// File: rtl/pipe4_pkg.sv
// pipe4_pkg: shared definitions for the pipe4 issue stage.
//   - func encodings for the 4-stage register/ALU/writeback/memory pipe
//   - bit positions of the fields inside a 24-bit instruction word
//   - source-use decode (which register sources a func reads)
//   - issue FSM state type
package pipe4_pkg;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_AND   = 4'd2;
  localparam logic [3:0] FN_PASSA = 4'd3;
  localparam logic [3:0] FN_PASSB = 4'd4;
  localparam logic [3:0] FN_OR    = 4'd5;
  localparam logic [3:0] FN_XOR   = 4'd6;
  localparam logic [3:0] FN_SLT   = 4'd7;
  localparam logic [3:0] FN_NOT   = 4'd8;
  localparam logic [3:0] FN_NOTB  = 4'd9;
  localparam logic [3:0] FN_SHR   = 4'd10;
  localparam logic [3:0] FN_SHL   = 4'd11;
  // Pass-A of R0 into R0 and a store to the reserved scratch address.
  localparam logic [3:0] FN_BUBBLE = FN_PASSA;

  // Instruction word: {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
  localparam int INSTR_W  = 24;
  localparam int FUNC_LSB = 20;
  localparam int RD_LSB   = 16;
  localparam int RS1_LSB  = 12;
  localparam int RS2_LSB  = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  function automatic logic uses_rs1(input logic [3:0] fn);
    logic used;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT,
      FN_PASSA, FN_NOT, FN_SHR, FN_SHL: used = 1'b1;
      default:                          used = 1'b0;
    endcase
    return used;
  endfunction

  function automatic logic uses_rs2(input logic [3:0] fn);
    logic used;
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT,
      FN_PASSB, FN_NOTB: used = 1'b1;
      default:           used = 1'b0;
    endcase
    return used;
  endfunction

  // func 12..15 have no pipe meaning.
  function automatic logic is_legal(input logic [3:0] fn);
    return (fn <= FN_SHL);
  endfunction

endpackage

// File: rtl/pipe4_instr_fifo.sv
// pipe4_instr_fifo: synchronous instruction buffer with flush.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write request / word (ignored when full)
//   pop             read request (ignored when empty)
//   flush           empty the buffer; wins over push and pop
//   rdata           head word (valid when !empty)
//   full, empty     occupancy flags from the registered count
module pipe4_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage write; contents need no reset because empty gates their use
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pipe4_issue.sv
// pipe4_issue: issue/decode stage feeding the 4-stage pipe, which has no
// forwarding and no valid bit. A read-after-write scoreboard holds back any
// head instruction that reads a register still in flight, and a harmless
// bubble (R0 <- R0, store R0 to SCRATCH_ADDR) is issued whenever nothing can go.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid, in_instr       instruction word in; accepted when in_ready
//   in_ready                 buffer not full
//   flush                    drop all buffered, un-issued words (scoreboard kept)
//   rs1, rs2, rd, func, addr registered fields to the pipe
//   out_bubble               current fields are a bubble
//   err_illegal              one-cycle pulse when an illegal func is dropped
// Optional build macro PIPE4_ISSUE_PERF_EN adds saturating 16-bit counters
// perf_issued (ISSUE cycles) and perf_stalls (STALL cycles).
module pipe4_issue
  import pipe4_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         HAZARD_DEPTH = 3,
  parameter logic [7:0] SCRATCH_ADDR = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [23:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic [3:0]  rs1,
  output logic [3:0]  rs2,
  output logic [3:0]  rd,
  output logic [3:0]  func,
  output logic [7:0]  addr,
  output logic        out_bubble,
  output logic        err_illegal
`ifdef PIPE4_ISSUE_PERF_EN
  ,
  output logic [15:0] perf_issued,
  output logic [15:0] perf_stalls
`endif
);

  logic [INSTR_W-1:0] head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;
  logic               issue_s;
  logic               illegal_s;
  logic               hazard_s;
  logic [3:0]         head_func_s, head_rd_s, head_rs1_s, head_rs2_s;
  logic [7:0]         head_addr_s;
  logic               sb_v_r  [HAZARD_DEPTH];
  logic [3:0]         sb_rd_r [HAZARD_DEPTH];
  state_t             state_r, state_next_s;

  assign in_ready = !fifo_full_s;
  assign push_s   = in_valid && in_ready && !flush;

  pipe4_instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush),
    .wdata (in_instr),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign head_func_s = head_s[FUNC_LSB +: 4];
  assign head_rd_s   = head_s[RD_LSB +: 4];
  assign head_rs1_s  = head_s[RS1_LSB +: 4];
  assign head_rs2_s  = head_s[RS2_LSB +: 4];
  assign head_addr_s = head_s[ADDR_LSB +: 8];

  // Hazard: any valid in-flight rd matches a source the head actually reads
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      hazard_s = hazard_s | (sb_v_r[i] &&
                 ((uses_rs1(head_func_s) && (sb_rd_r[i] == head_rs1_s)) ||
                  (uses_rs2(head_func_s) && (sb_rd_r[i] == head_rs2_s))));
    end
  end

  // Issue decision; an illegal head is dropped and reported as an idle cycle
  always_comb begin
    state_next_s = ST_IDLE;
    pop_s        = 1'b0;
    issue_s      = 1'b0;
    illegal_s    = 1'b0;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else if (fifo_empty_s) begin
      state_next_s = ST_IDLE;
    end else if (!is_legal(head_func_s)) begin
      state_next_s = ST_IDLE;
      pop_s        = 1'b1;
      illegal_s    = 1'b1;
    end else if (hazard_s) begin
      state_next_s = ST_STALL;
    end else begin
      state_next_s = ST_ISSUE;
      pop_s        = 1'b1;
      issue_s      = 1'b1;
    end
  end

  // FSM state register; the state mirrors what the output fields hold
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  assign out_bubble = (state_r != ST_ISSUE);

  // Registered pipe fields: the head's fields on issue, bubble otherwise
  always_ff @(posedge clk) begin
    if (rst || !issue_s) begin
      func <= FN_BUBBLE;
      rd   <= 4'd0;
      rs1  <= 4'd0;
      rs2  <= 4'd0;
      addr <= SCRATCH_ADDR;
    end else begin
      func <= head_func_s;
      rd   <= head_rd_s;
      rs1  <= head_rs1_s;
      rs2  <= head_rs2_s;
      addr <= head_addr_s;
    end
  end

  // Illegal-drop pulse
  always_ff @(posedge clk) begin
    if (rst) err_illegal <= 1'b0;
    else     err_illegal <= illegal_s;
  end

  // Scoreboard shift register; flush leaves it alone since issued writes are real
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HAZARD_DEPTH; i++) begin
        sb_v_r[i]  <= 1'b0;
        sb_rd_r[i] <= 4'd0;
      end
    end else begin
      sb_v_r[0]  <= issue_s;
      sb_rd_r[0] <= issue_s ? head_rd_s : 4'd0;
      for (int i = 1; i < HAZARD_DEPTH; i++) begin
        sb_v_r[i]  <= sb_v_r[i-1];
        sb_rd_r[i] <= sb_rd_r[i-1];
      end
    end
  end

`ifdef PIPE4_ISSUE_PERF_EN
  // Saturating ISSUE/STALL cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= 16'd0;
      perf_stalls <= 16'd0;
    end else begin
      if ((state_r == ST_ISSUE) && (perf_issued != 16'hFFFF))
        perf_issued <= perf_issued + 16'd1;
      if ((state_r == ST_STALL) && (perf_stalls != 16'hFFFF))
        perf_stalls <= perf_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe4_issue.sv
// tb_pipe4_issue: table-driven directed bench for pipe4_issue.
// Each vector drives one cycle of inputs; the outputs seen 1 time unit after
// the following rising edge are compared against a hand-computed record
// {in_ready, out_bubble, err_illegal, func, rd, rs1, rs2, addr}.
module tb_pipe4_issue;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush;
  logic [23:0] in_instr;
  logic        in_ready, out_bubble, err_illegal;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
`ifdef PIPE4_ISSUE_PERF_EN
  logic [15:0] perf_issued, perf_stalls;
`endif

  logic [26:0] act;
  assign act = {in_ready, out_bubble, err_illegal, func, rd, rs1, rs2, addr};

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe4_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .func        (func),
    .addr        (addr),
    .out_bubble  (out_bubble),
    .err_illegal (err_illegal)
`ifdef PIPE4_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stalls (perf_stalls)
`endif
  );

  typedef struct {
    logic        r;
    logic        v;
    logic [23:0] ins;
    logic        fl;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic [7:0] a);
    return {f, d, s1, s2, a};
  endfunction

  // Bubble: func 3, registers 0, scratch address 8'hFF
  function automatic logic [26:0] eb(input logic rdy);
    return {rdy, 1'b1, 1'b0, 4'd3, 12'd0, 8'hFF};
  endfunction

  // Bubble with the illegal pulse
  function automatic logic [26:0] ee(input logic rdy);
    return {rdy, 1'b1, 1'b1, 4'd3, 12'd0, 8'hFF};
  endfunction

  // Issued word: fields appear in instruction order
  function automatic logic [26:0] ei(input logic rdy, input logic [23:0] ins);
    return {rdy, 1'b0, 1'b0, ins};
  endfunction

  task automatic add(input logic r, input logic v, input logic [23:0] ins,
                     input logic fl, input logic [26:0] e);
    vec_t t;
    t.r = r; t.v = v; t.ins = ins; t.fl = fl; t.exp = e;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [23:0] ins, input logic fl);
    rst = r; in_valid = v; in_instr = ins; flush = fl;
  endtask

  task automatic step_check(input string nm, input logic [26:0] e);
    @(posedge clk);
    #1;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got {rdy,bub,err,func,rd,rs1,rs2,addr}=%h expected %h", nm, act, e);
    end
  endtask

  initial begin
    logic [23:0] i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_h, i_x1, i_x2, i_x3, i_x4;
    logic [23:0] i_p, i_q, i_z, i_r, i_a2, i_b2, i_c2, i_d2;

    drive(1'b1, 1'b0, 24'd0, 1'b0);

    i_a  = mk(4'd0,  4'd5,  4'd1,  4'd2,  8'h10);  // ADD rd5, r1, r2
    i_b  = mk(4'd0,  4'd6,  4'd5,  4'd3,  8'h11);  // ADD rd6, r5, r3
    i_c  = mk(4'd1,  4'd7,  4'd1,  4'd2,  8'h12);  // SUB rd7, r1, r2
    i_d  = mk(4'd8,  4'd8,  4'd3,  4'd7,  8'h13);  // NOT rd8, r3 (rs2 field unused)
    i_e  = mk(4'd13, 4'd9,  4'd1,  4'd2,  8'h20);  // illegal
    i_f  = mk(4'd4,  4'd10, 4'd8,  4'd9,  8'h22);  // PASSB reads r9 only
    i_g  = mk(4'd0,  4'd1,  4'd2,  4'd3,  8'h30);
    i_h  = mk(4'd0,  4'd4,  4'd1,  4'd1,  8'h31);  // depends on G
    i_x1 = mk(4'd0,  4'd11, 4'd15, 4'd15, 8'h40);
    i_x2 = mk(4'd0,  4'd12, 4'd15, 4'd15, 8'h41);
    i_x3 = mk(4'd0,  4'd13, 4'd15, 4'd15, 8'h42);
    i_x4 = mk(4'd0,  4'd9,  4'd15, 4'd15, 8'h43);

    // Reset held two cycles, then released idle
    add(1'b1, 1'b0, 24'd0, 1'b0, eb(1'b1));
    add(1'b1, 1'b0, 24'd0, 1'b0, eb(1'b1));
    add(1'b0, 1'b0, 24'd0, 1'b0, eb(1'b1));
    // RAW dependency: exactly three bubbles
    add(1'b0, 1'b1, i_a, 1'b0, eb(1'b1));
    add(1'b0, 1'b1, i_b, 1'b0, ei(1'b1, i_a));
    add(1'b0, 1'b0, 24'd0, 1'b0, eb(1'b1));
    add(1'b0, 1'b0, 24'd0, 1'b0, eb(1'b1));
    add(1'b0, 1'b0, 24'd0, 1'b0, eb(1'b1));
    add(1'b0, 1'b0, 24'd0, 1'b0, ei(1'b1, i_b));
    // Independent words back-to-back; NOT ignores its rs2 field (= in-flight rd7)
    add(1'b0, 1'b1, i_c, 1'b0, eb(1'b1));
    add(1'b0, 1'b1, i_d, 1'b0, ei(1'b1, i_c));
    add(1'b0, 1'b0, 24'd0, 1'b0, ei(1'b1, i_d));
    add(1'b0, 1'b0, 24'd0, 1'b0, eb(1'b1));
    // Illegal func dropped with one-cycle pulse; it leaves no scoreboard entry
    add(1'b0, 1'b1, i_e, 1'b0, eb(1'b1));
    add(1'b0, 1'b1, i_f, 1'b0, ee(1'b1));
    add(1'b0, 1'b0, 24'd0, 1'b0, ei(1'b1, i_f));
    add(1'b0, 1'b0, 24'd0, 1'b0, eb(1'b1));
    // Fill the FIFO behind a stalled head; full refuses push even with a pop
    add(1'b1, 1'b0, 24'd0, 1'b0, eb(1'b1));
    add(1'b0, 1'b1, i_g,  1'b0, eb(1'b1));
    add(1'b0, 1'b1, i_h,  1'b0, ei(1'b1, i_g));
    add(1'b0, 1'b1, i_x1, 1'b0, eb(1'b1));
    add(1'b0, 1'b1, i_x2, 1'b0, eb(1'b1));
    add(1'b0, 1'b1, i_x3, 1'b0, eb(1'b0));
    add(1'b0, 1'b1, i_x4, 1'b0, ei(1'b1, i_h));
    add(1'b0, 1'b1, i_x4, 1'b0, ei(1'b1, i_x1));
    add(1'b0, 1'b0, 24'd0, 1'b0, ei(1'b1, i_x2));
    add(1'b0, 1'b0, 24'd0, 1'b0, ei(1'b1, i_x3));
    add(1'b0, 1'b0, 24'd0, 1'b0, ei(1'b1, i_x4));
    add(1'b0, 1'b0, 24'd0, 1'b0, eb(1'b1));

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].v, vecs[i].ins, vecs[i].fl);
      step_check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Flush drops the queued dependent word and a simultaneous push,
    // but the scoreboard still remembers rd4
    i_p = mk(4'd0, 4'd4, 4'd1, 4'd2, 8'h50);
    i_q = mk(4'd0, 4'd5, 4'd4, 4'd2, 8'h51);
    i_z = mk(4'd0, 4'd2, 4'd1, 4'd1, 8'h52);
    i_r = mk(4'd1, 4'd6, 4'd4, 4'd3, 8'h53);
    drive(1'b0, 1'b1, i_p, 1'b0);    step_check("flush_push_p", eb(1'b1));
    drive(1'b0, 1'b1, i_q, 1'b0);    step_check("flush_issue_p", ei(1'b1, i_p));
    drive(1'b0, 1'b1, i_z, 1'b1);    step_check("flush_cycle", eb(1'b1));
    drive(1'b0, 1'b1, i_r, 1'b0);    step_check("flush_push_r", eb(1'b1));
    drive(1'b0, 1'b0, 24'd0, 1'b0);  step_check("flush_r_stall", eb(1'b1));
    step_check("flush_issue_r", ei(1'b1, i_r));
    step_check("flush_nothing_left", eb(1'b1));

    // Reset mid-operation discards buffered words and scoreboard
    i_a2 = mk(4'd0, 4'd3, 4'd1, 4'd2, 8'h60);
    i_b2 = mk(4'd0, 4'd7, 4'd3, 4'd3, 8'h61);
    i_c2 = mk(4'd0, 4'd8, 4'd1, 4'd1, 8'h62);
    i_d2 = mk(4'd1, 4'd9, 4'd3, 4'd3, 8'h63);
    drive(1'b0, 1'b1, i_a2, 1'b0);   step_check("rst_push_a2", eb(1'b1));
    drive(1'b0, 1'b1, i_b2, 1'b0);   step_check("rst_issue_a2", ei(1'b1, i_a2));
    drive(1'b1, 1'b1, i_c2, 1'b0);   step_check("rst_mid", eb(1'b1));
    drive(1'b0, 1'b1, i_d2, 1'b0);   step_check("rst_after_empty", eb(1'b1));
    drive(1'b0, 1'b0, 24'd0, 1'b0);  step_check("rst_sb_cleared", ei(1'b1, i_d2));
    step_check("rst_nothing_left", eb(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
